// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative RV32M multiply/divide unit.
// The pipeline drives the master side; muldiv_unit consumes the slave side.
interface muldiv_unit_if #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 5
);
  logic               start;
  logic               kill;
  logic [2:0]         op;
  logic [D_WIDTH-1:0] a;
  logic [D_WIDTH-1:0] b;
  logic [A_WIDTH-1:0] rd_in;
  logic               busy;
  logic               done;
  logic [D_WIDTH-1:0] result;
  logic [A_WIDTH-1:0] rd_out;

  modport master (output start, kill, op, a, b, rd_in,
                  input  busy, done, result, rd_out);
  modport slave  (input  start, kill, op, a, b, rd_in,
                  output busy, done, result, rd_out);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a combinational one.
module muldiv_unit #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  io
);
  localparam int CW = $clog2(D_WIDTH + 1);
  localparam logic [D_WIDTH-1:0] MIN_NEG = {1'b1, {(D_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t               r_state;
  logic [2:0]           r_op;
  logic [A_WIDTH-1:0]   r_rd;
  logic [D_WIDTH-1:0]   r_m;
  logic [2*D_WIDTH-1:0] r_p;
  logic                 r_neg, r_spec, r_quick, r_pend, r_done;
  logic [CW-1:0]        r_cnt;
  logic [D_WIDTH-1:0]   r_stage, r_result;
  logic [A_WIDTH-1:0]   r_stage_rd, r_rd_out;

  logic                 w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_is_div, w_dz, w_ovf, w_neg;
  logic [D_WIDTH-1:0]   w_a_mag, w_b_mag, w_spec_val;
  logic [D_WIDTH:0]     w_madd, w_cand;
  logic [D_WIDTH-1:0]   w_dsub, w_q, w_r, w_fin;
  logic                 w_ge;
  logic [2*D_WIDTH-1:0] w_pc;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*D_WIDTH-1:0] w_fast;
`endif

  // Operand decode for the request presented in IDLE
  always_comb begin
    w_a_sgn  = (io.op == 3'd1) || (io.op == 3'd2) || (io.op == 3'd4) || (io.op == 3'd6);
    w_b_sgn  = (io.op == 3'd1) || (io.op == 3'd4) || (io.op == 3'd6);
    w_a_neg  = w_a_sgn && io.a[D_WIDTH-1];
    w_b_neg  = w_b_sgn && io.b[D_WIDTH-1];
    w_a_mag  = w_a_neg ? -io.a : io.a;
    w_b_mag  = w_b_neg ? -io.b : io.b;
    w_is_div = io.op[2];
    w_dz     = w_is_div && (io.b == '0);
    w_ovf    = w_is_div && !io.op[0] && (io.a == MIN_NEG) && (io.b == '1);
    // REM follows the dividend sign; everything else follows the operand sign XOR
    w_neg    = (w_is_div && io.op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    if (w_dz) w_spec_val = io.op[1] ? io.a : '1;
    else      w_spec_val = io.op[1] ? '0 : io.a;
  end

`ifdef MULDIV_FAST_MUL_EN
  assign w_fast = {{D_WIDTH{1'b0}}, w_a_mag} * {{D_WIDTH{1'b0}}, w_b_mag};
`endif

  // One iteration of shift-add / shift-subtract
  assign w_madd = {1'b0, r_p[2*D_WIDTH-1:D_WIDTH]} + {1'b0, r_m};
  assign w_cand = r_p[2*D_WIDTH-1:D_WIDTH-1];
  assign w_ge   = (w_cand >= {1'b0, r_m});
  assign w_dsub = w_cand[D_WIDTH-1:0] - r_m;

  // Sign correction and result select
  assign w_pc = r_neg ? -r_p : r_p;
  assign w_q  = r_p[D_WIDTH-1:0];
  assign w_r  = r_p[2*D_WIDTH-1:D_WIDTH];

  always_comb begin
    w_fin = r_p[D_WIDTH-1:0];
    if (!r_spec) begin
      if (!r_op[2])     w_fin = (r_op[1:0] == 2'b00) ? w_pc[D_WIDTH-1:0] : w_pc[2*D_WIDTH-1:D_WIDTH];
      else if (!r_op[1]) w_fin = r_neg ? -w_q : w_q;
      else              w_fin = r_neg ? -w_r : w_r;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_rd       <= '0;
      r_m        <= '0;
      r_p        <= '0;
      r_neg      <= 1'b0;
      r_spec     <= 1'b0;
      r_quick    <= 1'b0;
      r_pend     <= 1'b0;
      r_done     <= 1'b0;
      r_stage    <= '0;
      r_stage_rd <= '0;
      r_result   <= '0;
      r_rd_out   <= '0;
    end else begin
      r_done <= 1'b0;
      r_pend <= 1'b0;
      // Short-path results sit one extra cycle so done lands two edges after acceptance
      if (r_pend) begin
        r_result <= r_stage;
        r_rd_out <= r_stage_rd;
        r_done   <= 1'b1;
      end
      if (io.kill) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: if (io.start) begin
            r_op  <= io.op;
            r_rd  <= io.rd_in;
            r_neg <= w_neg;
            r_cnt <= '0;
            if (w_dz || w_ovf) begin
              r_p     <= {{D_WIDTH{1'b0}}, w_spec_val};
              r_spec  <= 1'b1;
              r_quick <= 1'b1;
              r_state <= FIN;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!w_is_div) begin
              r_p     <= w_fast;
              r_spec  <= 1'b0;
              r_quick <= 1'b1;
              r_state <= FIN;
`endif
            end else begin
              r_p     <= {{D_WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
              r_m     <= w_is_div ? w_b_mag : w_a_mag;
              r_spec  <= 1'b0;
              r_quick <= 1'b0;
              r_state <= CALC;
            end
          end
          CALC: begin
            if (r_cnt == CW'(D_WIDTH)) begin
              r_state <= FIN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
              if (r_op[2])    r_p <= w_ge ? {w_dsub, r_p[D_WIDTH-2:0], 1'b1} : {r_p[2*D_WIDTH-2:0], 1'b0};
              else if (r_p[0]) r_p <= {w_madd, r_p[D_WIDTH-1:1]};
              else            r_p <= {1'b0, r_p[2*D_WIDTH-1:1]};
            end
          end
          FIN: begin
            if (r_quick) begin
              r_stage    <= w_fin;
              r_stage_rd <= r_rd;
              r_pend     <= 1'b1;
            end else begin
              r_result <= w_fin;
              r_rd_out <= r_rd;
              r_done   <= 1'b1;
            end
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign io.busy   = (r_state != IDLE);
  assign io.done   = r_done;
  assign io.result = r_result;
  assign io.rd_out = r_rd_out;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a reference RV32M model predicts result, tag
// and completion edge at acceptance; completions are popped and compared.
module tb_muldiv_unit;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus ();
  muldiv_unit #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

  typedef struct {
    logic [DW-1:0] res;
    logic [AW-1:0] rd;
    int            due;
  } exp_t;

  exp_t          scb[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            edges = 0;
  int            n_acc = 0;
  logic [DW-1:0] last_res = '0;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_op(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [63:0] sa, sbv, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (op)
      3'd0: begin p = sa * sbv; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (ovf) return a;
        p = sa / sbv; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return '1;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return '0;
        p = sa % sbv; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int lat(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 2;
`endif
    return DW + 2;
  endfunction

  // Completion checker and acceptance tracker, sampled mid-cycle
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (bus.done) begin
        if (scb.size() == 0) chk("spurious_done", 64'(bus.done), 64'd0);
        else begin
          e = scb.pop_front();
          chk("result", 64'(bus.result), 64'(e.res));
          chk("rd_out", 64'(bus.rd_out), 64'(e.rd));
          chk("done_edge", 64'(edges), 64'(e.due));
          last_res = e.res;
        end
      end
      if (bus.kill) begin
        if (bus.busy && scb.size() > 0) scb.delete(scb.size() - 1);
      end else if (bus.start && !bus.busy) begin
        n_acc++;
        scb.push_back('{ref_op(bus.op, bus.a, bus.b), bus.rd_in, edges + 1 + lat(bus.op, bus.a, bus.b)});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [AW-1:0] rd);
    int t = 0;
    while (bus.busy && t < 200) begin tick(); t++; end
    if (bus.busy) chk("issue_wait", 64'(bus.busy), 64'd0);
    bus.op = op; bus.a = a; bus.b = b; bus.rd_in = rd;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((scb.size() != 0 || bus.busy) && t < 400) begin tick(); t++; end
    chk("drain", 64'(scb.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    bus.start = 1'b0; bus.kill = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.rd_in = '0;
    repeat (3) tick();
    chk("rst_busy",   64'(bus.busy),   64'd0);
    chk("rst_done",   64'(bus.done),   64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_rd_out", 64'(bus.rd_out), 64'd0);
    rst_n = 1'b1;
    tick();

    // Directed values, each drained so latency is measured from idle
    issue(3'd0, -32'sd3, 32'd7, 5'd5);                 drain();
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);   drain();
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);   drain();
    issue(3'd2, -32'sd5, 32'hFFFF_FFFF, 5'd3);         drain();
    issue(3'd4, -32'sd7, 32'd2, 5'd4);                 drain();
    issue(3'd6, -32'sd7, 32'd2, 5'd6);                 drain();
    issue(3'd5, 32'd100, 32'd7, 5'd7);                 drain();
    issue(3'd7, 32'd100, 32'd7, 5'd8);                 drain();
    issue(3'd4, 32'd5, 32'd0, 5'd9);                   drain();
    issue(3'd7, 32'd5, 32'd0, 5'd10);                  drain();
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);  drain();
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);  drain();

    // Random mix issued back-to-back, including zero divisors
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] ra, rb;
      ra = $urandom;
      rb = (i % 5 == 0) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom);
      issue(3'($urandom_range(0, 7)), ra, rb, 5'(i));
    end
    drain();

    // start held high: one acceptance per completion
    acc0 = n_acc;
    bus.op = 3'd5; bus.a = 32'd100; bus.b = 32'd7; bus.rd_in = 5'd3;
    bus.start = 1'b1;
    repeat (40) tick();
    bus.start = 1'b0;
    chk("hold_accepts", 64'(n_acc - acc0), 64'd2);
    drain();

    // start pulse mid-CALC is ignored
    issue(3'd5, 32'd200, 32'd9, 5'd4);
    repeat (5) tick();
    bus.op = 3'd0; bus.a = 32'd1; bus.b = 32'd1; bus.rd_in = 5'd30;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    drain();

    // kill mid-DIVU: no done, result unchanged
    issue(3'd5, 32'd1000, 32'd3, 5'd9);
    repeat (9) tick();
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    chk("kill_busy", 64'(bus.busy), 64'd0);
    repeat (40) tick();
    chk("kill_result", 64'(bus.result), 64'(last_res));
    chk("kill_queue", 64'(scb.size()), 64'd0);

    // kill beats start in IDLE
    bus.op = 3'd0; bus.a = 32'd2; bus.b = 32'd2; bus.rd_in = 5'd15;
    bus.start = 1'b1; bus.kill = 1'b1;
    tick();
    bus.start = 1'b0; bus.kill = 1'b0;
    chk("kill_start_busy", 64'(bus.busy), 64'd0);
    repeat (40) tick();
    issue(3'd0, 32'd3, 32'd4, 5'd1);
    drain();

    // reset mid-DIV discards the operation
    issue(3'd4, -32'sd100, 32'd3, 5'd7);
    repeat (5) tick();
    rst_n = 1'b0;
    scb.delete();
    repeat (2) tick();
    chk("midrst_busy",   64'(bus.busy),   64'd0);
    chk("midrst_done",   64'(bus.done),   64'd0);
    chk("midrst_result", 64'(bus.result), 64'd0);
    chk("midrst_rd_out", 64'(bus.rd_out), 64'd0);
    rst_n = 1'b1;
    last_res = '0;
    repeat (50) tick();
    chk("midrst_quiet", 64'(scb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide execution unit implementing the RV32M operations for the processor datapath, parametrised in data width. It sits beside the ALU in the execute stage. It accepts operands and a funct3-coded operation on a start pulse and holds `busy` so control can stall the pipeline. It returns a registered result with the destination register tag and a one-cycle `done` pulse.

## Interface
- `D_WIDTH`, 32: operand/result width; must be even and at least 8.
- `A_WIDTH`, 5: register-address (tag) width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  request; sampled only when `busy`=0.
- `kill`  in  1  abort of the in-flight operation; synchronous.
- `op`  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `a`  in  D_WIDTH  rs1 operand.
- `b`  in  D_WIDTH  rs2 operand.
- `rd_in`  in  A_WIDTH  destination tag captured with the operands.
- `busy`  out  1  high while an operation is in flight (state ≠ IDLE).
- `done`  out  1  one-cycle pulse; `result` and `rd_out` are valid in that cycle.
- `result`  out  D_WIDTH  registered result; holds its value until the next completion.
- `rd_out`  out  A_WIDTH  tag of the completed operation.

## Operation
- States: IDLE, CALC, FIN.
- IDLE:
  - `start`=1 captures `op`, `rd_in`, operand magnitudes and result sign, then moves to CALC with counter = 0.
  - Special cases go directly to FIN and skip CALC: divide-by-zero, signed overflow, and MUL/MULH* when MULDIV_FAST_MUL_EN is defined.
- CALC: one iteration per cycle; leaves for FIN after exactly D_WIDTH iterations.
  - Multiply: radix-2 shift-add into a 2·D_WIDTH product register.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIN: applies sign correction, loads `result` and `rd_out`, asserts `done` on the next cycle, and returns to IDLE.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: `a` signed, `b` unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV: quotient is negated when operand signs differ.
  - REM: remainder takes the sign of `a`.
- Result selection: MUL takes the low D_WIDTH bits of the product; MULH/MULHSU/MULHU take the high D_WIDTH bits.
- Divide-by-zero (`b`=0): DIV/DIVU return all-ones; REM/REMU return `a`.
- Signed overflow (DIV/REM with `a`=most-negative and `b`=−1): DIV returns `a`; REM returns 0.
- `start` while `busy`=1 is ignored; it is not queued.
- `kill`=1 in any state returns to IDLE next edge with no `done`, and leaves `result`/`rd_out` unchanged. If `kill` and `start` are both high in IDLE, `kill` wins and nothing is accepted.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, counter 0, `busy`=0, `done`=0, `result`=0, `rd_out`=0. Reset mid-operation discards the operation with no `done`.
- Edge numbering: the start is accepted at edge N.
  - Iterative path: `busy`=1 after edges N through N+D_WIDTH+1; `done`=1 for the single cycle after edge N+D_WIDTH+2.
  - Special-case or fast path: `busy`=1 for one cycle only; `done`=1 after edge N+2.
- `busy` is 0 in the `done` cycle, so a new `start` may be issued in that cycle (back-to-back operation).
- Outputs change only on clock edges; `busy` is decoded from state registers only.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: MUL/MULH/MULHSU/MULHU use a single-cycle combinational D_WIDTH×D_WIDTH multiplier and go IDLE→FIN, with `done` after edge N+2. Division remains iterative.
- `MULDIV_FAST_MUL_EN` undefined: all multiplies use the iterative shift-add path with D_WIDTH+3-cycle completion. No multiplier array is synthesised.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles during a DIV → `busy`=0, `done`=0, `result`=0, `rd_out`=0, and no `done` afterwards.
- Signed multiply, D_WIDTH=32:
  - MUL a=−3, b=7, rd_in=5 → `result`=0xFFFFFFEB, `rd_out`=5, `done` exactly after edge N+34 (macro off) or N+2 (macro on).
  - MULH a=0x80000000, b=0x80000000 → 0x40000000.
  - MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE.
- Division signs:
  - DIV a=−7, b=2 → 0xFFFFFFFD.
  - REM a=−7, b=2 → 0xFFFFFFFF.
  - DIVU a=100, b=7 → 14.
  - REMU a=100, b=7 → 2.
- Corner cases:
  - DIV a=5, b=0 → 0xFFFFFFFF.
  - REMU a=5, b=0 → 5.
  - DIV a=0x80000000, b=−1 → 0x80000000.
  - REM a=0x80000000, b=−1 → 0.
  - Each of these completes with `done` after edge N+2.
- Handshake: `start` held high for 40 cycles → exactly one operation per `done`; the next op is accepted in the `done` cycle; a `start` pulse mid-CALC is ignored.
- Kill: assert `kill` 10 cycles into a DIVU → IDLE next edge, no `done`, `result` keeps its previous value; a following MUL 3×4 → 12.
